// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: shares one SD block channel between the floppy track
// loader (client 0) and the HDD sector handler (client 1). Each granted
// burst is issued one sector at a time and the LBA advances per sector.
// Optional macro SDARB_TIMEOUT_EN adds a watchdog that aborts a burst when
// sd_ack stays quiet for TIMEOUT_CYC cycles and pulses err.
module sd_req_arbiter #(
  parameter int          MAX_SECT    = 16,
  parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
) (
  input  logic        CLK_VIDEO,
  input  logic        reset,
  input  logic        c0_req,
  input  logic        c0_wr,
  input  logic [31:0] c0_lba,
  input  logic [4:0]  c0_cnt,
  output logic        c0_done,
  output logic        c0_busy,
  input  logic        c1_req,
  input  logic        c1_wr,
  input  logic [31:0] c1_lba,
  input  logic [4:0]  c1_cnt,
  output logic        c1_done,
  output logic        c1_busy,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  output logic        act_client,
  output logic [3:0]  act_sec,
  output logic        cpu_wait,
  output logic        err
);

  localparam logic [4:0] MAX_N = 5'(MAX_SECT);

  typedef enum logic [1:0] {IDLE, XFER, WAITFALL} state_t;

  state_t      state, state_nx;
  logic        rr, rr_nx;
  logic        old_ack;
  logic [4:0]  n, n_nx;
  logic [31:0] lba_nx;
  logic        rd_nx, wr_nx, client_nx, wait_nx;
  logic        busy0_nx, busy1_nx, done0_nx, done1_nx, err_nx;
  logic [3:0]  sec_nx;

  logic        rise, fall, last;
  logic        v0, v1, gnt_valid, gnt_id, g_wr;
  logic [31:0] g_lba;
  logic [4:0]  g_cnt, g_n;

  assign rise = ~old_ack & sd_ack;
  assign fall = old_ack & ~sd_ack;
  assign last = ({1'b0, act_sec} == (n - 5'd1));

  // A client whose done is showing this cycle is still holding req; mask it
  // so it cannot be re-granted before it has had a chance to drop req.
  assign v0        = c0_req & ~c0_done;
  assign v1        = c1_req & ~c1_done;
  assign gnt_valid = v0 | v1;
  assign gnt_id    = (v0 & v1) ? rr : v1;
  assign g_wr      = gnt_id ? c1_wr  : c0_wr;
  assign g_lba     = gnt_id ? c1_lba : c0_lba;
  assign g_cnt     = gnt_id ? c1_cnt : c0_cnt;
  assign g_n       = (g_cnt > MAX_N) ? MAX_N : g_cnt;

`ifdef SDARB_TIMEOUT_EN
  logic [23:0] tmo_cnt, tmo_nx;
  logic        tmo_hit;

  assign tmo_hit = (state != IDLE) && !rise && !fall &&
                   (tmo_cnt == TIMEOUT_CYC - 24'd1);

  // Watchdog counter: restarts on grant and on any sd_ack edge.
  always_comb begin
    tmo_nx = tmo_cnt;
    if (state == IDLE || rise || fall) tmo_nx = '0;
    else                               tmo_nx = tmo_cnt + 24'd1;
  end

  // Watchdog counter register.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) tmo_cnt <= '0;
    else       tmo_cnt <= tmo_nx;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_nx  = state;
    rr_nx     = rr;
    n_nx      = n;
    lba_nx    = sd_lba;
    rd_nx     = sd_rd;
    wr_nx     = sd_wr;
    client_nx = act_client;
    sec_nx    = act_sec;
    wait_nx   = cpu_wait;
    busy0_nx  = c0_busy;
    busy1_nx  = c1_busy;
    done0_nx  = 1'b0;
    done1_nx  = 1'b0;
    err_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          n_nx = g_n;
          if (g_n == 5'd0) begin
            // Empty burst: acknowledge immediately, leave fairness alone.
            done0_nx = ~gnt_id;
            done1_nx = gnt_id;
          end else begin
            lba_nx    = g_lba;
            rd_nx     = ~g_wr;
            wr_nx     = g_wr;
            wait_nx   = 1'b1;
            busy0_nx  = ~gnt_id;
            busy1_nx  = gnt_id;
            client_nx = gnt_id;
            sec_nx    = '0;
            state_nx  = XFER;
          end
        end
      end
      XFER: begin
        if (rise) begin
          lba_nx = sd_lba + 32'd1;
          if (last) begin
            rd_nx = 1'b0;
            wr_nx = 1'b0;
          end
          state_nx = WAITFALL;
        end
      end
      WAITFALL: begin
        if (fall) begin
          if (!last) begin
            sec_nx   = act_sec + 4'd1;
            state_nx = XFER;
          end else begin
            done0_nx = ~act_client;
            done1_nx = act_client;
            busy0_nx = 1'b0;
            busy1_nx = 1'b0;
            wait_nx  = 1'b0;
            rr_nx    = ~act_client;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef SDARB_TIMEOUT_EN
    if (tmo_hit) begin
      rd_nx    = 1'b0;
      wr_nx    = 1'b0;
      err_nx   = 1'b1;
      done0_nx = ~act_client;
      done1_nx = act_client;
      busy0_nx = 1'b0;
      busy1_nx = 1'b0;
      wait_nx  = 1'b0;
      rr_nx    = ~act_client;
      state_nx = IDLE;
    end
`endif
  end

  // State and registered outputs; reset abandons any burst silently.
  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= 1'b0;
      old_ack    <= 1'b0;
      n          <= '0;
      sd_lba     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      act_client <= 1'b0;
      act_sec    <= '0;
      cpu_wait   <= 1'b0;
      c0_busy    <= 1'b0;
      c1_busy    <= 1'b0;
      c0_done    <= 1'b0;
      c1_done    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      rr         <= rr_nx;
      old_ack    <= sd_ack;
      n          <= n_nx;
      sd_lba     <= lba_nx;
      sd_rd      <= rd_nx;
      sd_wr      <= wr_nx;
      act_client <= client_nx;
      act_sec    <= sec_nx;
      cpu_wait   <= wait_nx;
      c0_busy    <= busy0_nx;
      c1_busy    <= busy1_nx;
      c0_done    <= done0_nx;
      c1_done    <= done1_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter (default build, watchdog disabled).
module tb_sd_req_arbiter;
  logic        CLK_VIDEO = 1'b0;
  logic        reset = 1'b1;
  logic        c0_req = 1'b0, c0_wr = 1'b0;
  logic [31:0] c0_lba = '0;
  logic [4:0]  c0_cnt = '0;
  logic        c0_done, c0_busy;
  logic        c1_req = 1'b0, c1_wr = 1'b0;
  logic [31:0] c1_lba = '0;
  logic [4:0]  c1_cnt = '0;
  logic        c1_done, c1_busy;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack = 1'b0;
  logic        act_client;
  logic [3:0]  act_sec;
  logic        cpu_wait, err;

  int checks = 0;
  int errors = 0;

  sd_req_arbiter #(.MAX_SECT(16), .TIMEOUT_CYC(24'd100)) dut (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_lba(c0_lba), .c0_cnt(c0_cnt),
    .c0_done(c0_done), .c0_busy(c0_busy),
    .c1_req(c1_req), .c1_wr(c1_wr), .c1_lba(c1_lba), .c1_cnt(c1_cnt),
    .c1_done(c1_done), .c1_busy(c1_busy),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .act_client(act_client), .act_sec(act_sec), .cpu_wait(cpu_wait), .err(err)
  );

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs/outputs are touched 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK_VIDEO);
    #1;
  endtask

  task automatic ack_cycle();
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_lba"},  sd_lba, 32'h0);
    chk({tag, "_ctl"},  {28'h0, sd_rd, sd_wr, cpu_wait, err}, 32'h0);
    chk({tag, "_cli"},  {27'h0, c0_busy, c1_busy, c0_done, c1_done, act_client}, 32'h0);
    chk({tag, "_sec"},  {28'h0, act_sec}, 32'h0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk_idle("rst");
    reset = 1'b0;
    tick();
    chk_idle("rst_rel");

    // c0 read, lba 0x41, 13 sectors
    c0_req = 1'b1; c0_wr = 1'b0; c0_lba = 32'h41; c0_cnt = 5'd13;
    tick();
    chk("t1_rd_grant", {30'h0, sd_rd, sd_wr}, 32'h2);
    chk("t1_wait", {30'h0, cpu_wait, c0_busy}, 32'h3);
    for (int i = 0; i < 13; i++) begin
      chk("t1_sec", {28'h0, act_sec}, i);
      chk("t1_lba", sd_lba, 32'h41 + i);
      chk("t1_rd_pre", {31'h0, sd_rd}, 32'h1);
      sd_ack = 1'b1;
      tick();
      chk("t1_lba_rise", sd_lba, 32'h42 + i);
      chk("t1_rd_rise", {31'h0, sd_rd}, (i == 12) ? 32'h0 : 32'h1);
      tick();  // ack held a second cycle: no second rise
      chk("t1_lba_hold", sd_lba, 32'h42 + i);
      chk("t1_wait_mid", {31'h0, cpu_wait}, 32'h1);
      sd_ack = 1'b0;
      tick();
      chk("t1_done", {31'h0, c0_done}, (i == 12) ? 32'h1 : 32'h0);
      chk("t1_wait_end", {31'h0, cpu_wait}, (i == 12) ? 32'h0 : 32'h1);
    end
    c0_req = 1'b0;
    tick();
    chk("t1_done_once", {30'h0, c0_done, c0_busy}, 32'h0);
    chk("t1_lba_after", sd_lba, 32'h4E);

    // c1 write, lba 7, 1 sector
    c1_req = 1'b1; c1_wr = 1'b1; c1_lba = 32'h7; c1_cnt = 5'd1;
    tick();
    chk("t2_dir", {30'h0, sd_rd, sd_wr}, 32'h1);
    chk("t2_cli", {30'h0, act_client, c1_busy}, 32'h3);
    sd_ack = 1'b1;
    tick();
    chk("t2_wr_drop", {31'h0, sd_wr}, 32'h0);
    chk("t2_lba", sd_lba, 32'h8);
    sd_ack = 1'b0;
    tick();
    chk("t2_done", {30'h0, c1_done, act_client}, 32'h3);
    c1_req = 1'b0;
    tick();

    // LBA wrap on c1 read
    c1_req = 1'b1; c1_wr = 1'b0; c1_lba = 32'hFFFF_FFFF; c1_cnt = 5'd2;
    tick();
    chk("t2w_lba0", sd_lba, 32'hFFFF_FFFF);
    ack_cycle();
    chk("t2w_wrap", sd_lba, 32'h0);
    chk("t2w_sec", {28'h0, act_sec}, 32'h1);
    ack_cycle();
    chk("t2w_done", {31'h0, c1_done}, 32'h1);
    c1_req = 1'b0;
    tick();

    // Simultaneous requests after reset: c0 first, c1 withdraws
    reset = 1'b1; tick(); reset = 1'b0;
    c0_req = 1'b1; c0_wr = 1'b0; c0_lba = 32'h100; c0_cnt = 5'd1;
    c1_req = 1'b1; c1_wr = 1'b1; c1_lba = 32'h200; c1_cnt = 5'd1;
    tick();
    chk("t3_first", {29'h0, act_client, sd_rd, sd_wr}, 32'h2);
    ack_cycle();
    chk("t3_c0_done", {31'h0, c0_done}, 32'h1);
    c0_req = 1'b0; c1_req = 1'b0;
    tick();
    chk("t3_withdraw", {28'h0, sd_rd, sd_wr, cpu_wait, c1_busy}, 32'h0);
    // rr now points at c1
    c0_req = 1'b1; c1_req = 1'b1;
    tick();
    chk("t3_rr_c1", {29'h0, act_client, sd_rd, sd_wr}, 32'h5);
    chk("t3_lba_c1", sd_lba, 32'h200);
    ack_cycle();
    chk("t3_c1_done", {31'h0, c1_done}, 32'h1);
    c1_req = 1'b0;
    tick();
    chk("t3_c0_next", {29'h0, act_client, sd_rd, sd_wr}, 32'h2);
    chk("t3_lba_c0", sd_lba, 32'h100);
    ack_cycle();
    chk("t3_c0_done2", {31'h0, c0_done}, 32'h1);
    c0_req = 1'b0;
    tick();

    // cnt = 0: immediate done, no SD activity
    c0_req = 1'b1; c0_cnt = 5'd0; c0_lba = 32'h55;
    tick();
    chk("t4_zero_done", {31'h0, c0_done}, 32'h1);
    chk("t4_zero_quiet", {29'h0, sd_rd, cpu_wait, c0_busy}, 32'h0);
    c0_req = 1'b0;
    tick();
    chk("t4_zero_after", {30'h0, c0_done, sd_rd}, 32'h0);

    // cnt = 20 clamps to 16 sectors
    c0_req = 1'b1; c0_cnt = 5'd20; c0_lba = 32'h1000;
    tick();
    for (int i = 0; i < 15; i++) ack_cycle();
    chk("t4_clamp_sec", {28'h0, act_sec}, 32'hF);
    chk("t4_clamp_nd", {31'h0, c0_done}, 32'h0);
    ack_cycle();
    chk("t4_clamp_done", {31'h0, c0_done}, 32'h1);
    chk("t4_clamp_lba", sd_lba, 32'h1010);
    c0_req = 1'b0;
    tick();

    // Reset after the 3rd rise of a 13-sector burst
    c0_req = 1'b1; c0_cnt = 5'd13; c0_lba = 32'h41;
    tick();
    ack_cycle(); ack_cycle();
    sd_ack = 1'b1;
    tick();
    chk("t5_pre_lba", sd_lba, 32'h44);
    reset = 1'b1; sd_ack = 1'b0;
    tick();
    chk_idle("t5_rst");
    reset = 1'b0;
    tick();
    chk("t5_restart_lba", sd_lba, 32'h41);
    chk("t5_restart", {27'h0, act_sec, sd_rd}, 32'h1);
    chk("t5_no_done", {31'h0, c0_done}, 32'h0);

    reset = 1'b1; c0_req = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
